// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the BUBBLE instruction-fetch stage: FSM state encodings,
// PC update selects and the address/data widths shared with the memories.
package fetch_unit_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter: asynchronously reset to RESET_PC, then loaded, incremented
// (wrapping at the top of the word-address space) or held each cycle.
module pc_register
  import fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INC:  pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      PC_LOAD: pc_d = load_value;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers fetched words into the IF/ID
// latch with a valid/ready handshake, and handles redirect flushes and a sticky halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_d, state_q;
  logic              if_valid_d, if_valid_q;
  logic [DATA_W-1:0] if_inst_d, if_inst_q;
  logic [ADDR_W-1:0] if_pc_d, if_pc_q;
  logic              halted_d, halted_q;
  logic [31:0]       fetch_count_d, fetch_count_q;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .sel        (pc_sel),
    .load_value (redirect_target),
    .pc         (pc)
  );

  always_comb begin
    state_d       = state_q;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;
    halted_d      = halted_q;
    pc_sel        = PC_HOLD;
    fetch_count_d = fetch_count_q;

    // The outgoing handshake completes regardless of what the FSM does this edge.
    if (if_valid_q && id_ready) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    case (state_q)
      FS_IDLE: begin
        state_d = FS_RUN;
      end
      FS_RUN: begin
        // Redirect wins over halt: the halting instruction is younger and gets flushed.
        if (redirect_valid) begin
          pc_sel     = PC_LOAD;
          if_valid_d = 1'b0;
        end else if (halt_req) begin
          if_valid_d = 1'b0;
          state_d    = FS_HALT;
          halted_d   = 1'b1;
        end else if (!if_valid_q || id_ready) begin
          if_inst_d  = imem_data;
          if_pc_d    = pc;
          if_valid_d = 1'b1;
          pc_sel     = PC_INC;
        end
      end
      FS_HALT: begin
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d    = FS_IDLE;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FS_IDLE;
      if_valid_q    <= 1'b0;
      if_inst_q     <= '0;
      if_pc_q       <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc;
  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: stimulus pushes expected {inst, pc} words into a queue,
// a negedge monitor pops and compares on every completed IF/ID handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [15:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .RESET_PC (16'd0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .id_ready        (id_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: imem[0]=A, imem[1]=B, otherwise {16'hC0DE, addr}.
  always_comb begin
    if (imem_addr == 16'h0000)      imem_data = 32'h0000_000A;
    else if (imem_addr == 16'h0001) imem_data = 32'h0000_000B;
    else                            imem_data = {16'hC0DE, imem_addr};
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [15:0] pc);
    exp_q.push_back({inst, pc});
  endtask

  // Monitor: a handshake completes at the next posedge whenever valid && ready here.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && id_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got pc=%h inst=%h expected none", if_pc, if_inst);
        end else begin
          e = exp_q.pop_front();
          if ({if_inst, if_pc} !== e) begin
            errors++;
            $display("FAIL xfer: got pc=%h inst=%h expected pc=%h inst=%h",
                     if_pc, if_inst, e[15:0], e[47:16]);
          end else begin
            $display("xfer pc=%h inst=%h count=%0d", if_pc, if_inst, fetch_count);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = 16'h0; halt_req = 1'b0;
    step(); step();
    check("rst_addr",   48'(imem_addr),   48'h0);
    check("rst_valid",  48'(if_valid),    48'h0);
    check("rst_inst",   48'(if_inst),     48'h0);
    check("rst_pc",     48'(if_pc),       48'h0);
    check("rst_halted", 48'(halted),      48'h0);
    check("rst_count",  48'(fetch_count), 48'h0);

    // Basic fetch after reset release with one IDLE bubble
    push(32'h0000_000A, 16'h0000);
    push(32'h0000_000B, 16'h0001);
    push(32'hC0DE_0002, 16'h0002);
    id_ready = 1'b1; rst = 1'b0;
    step();
    check("idle_bubble", 48'(if_valid), 48'h0);
    step();
    check("f0_pc",    48'(if_pc),       48'h0);
    check("f0_inst",  48'(if_inst),     48'hA);
    check("f0_count", 48'(fetch_count), 48'h0);
    step();
    check("f1_pc",    48'(if_pc),       48'h1);
    check("f1_count", 48'(fetch_count), 48'h1);
    step();
    check("f2_pc",    48'(if_pc),       48'h2);
    check("f2_count", 48'(fetch_count), 48'h2);

    // Stall three cycles on if_pc=2
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    48'(if_pc),       48'h2);
      check("stall_addr",  48'(imem_addr),   48'h3);
      check("stall_count", 48'(fetch_count), 48'h2);
    end
    id_ready = 1'b1;
    step();
    check("unstall_pc",    48'(if_pc),       48'h3);
    check("unstall_count", 48'(fetch_count), 48'h3);

    // Redirect while stalled flushes if_pc=3
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 16'h0040;
    step();
    check("redir_valid", 48'(if_valid),    48'h0);
    check("redir_addr",  48'(imem_addr),   48'h40);
    check("redir_count", 48'(fetch_count), 48'h3);
    redirect_valid = 1'b0; id_ready = 1'b1;
    push(32'hC0DE_0040, 16'h0040);
    step();
    check("redir_pc",   48'(if_pc),   48'h40);
    check("redir_inst", 48'(if_inst), 48'hC0DE_0040);

    // Redirect and halt together: redirect wins
    redirect_valid = 1'b1; redirect_target = 16'h0080; halt_req = 1'b1;
    step();
    check("rh_halted", 48'(halted),      48'h0);
    check("rh_valid",  48'(if_valid),    48'h0);
    check("rh_addr",   48'(imem_addr),   48'h80);
    check("rh_count",  48'(fetch_count), 48'h4);
    redirect_valid = 1'b0; halt_req = 1'b0;
    push(32'hC0DE_0080, 16'h0080);
    step();
    halt_req = 1'b1;
    step();
    check("halt_halted", 48'(halted),      48'h1);
    check("halt_valid",  48'(if_valid),    48'h0);
    check("halt_addr",   48'(imem_addr),   48'h81);
    check("halt_count",  48'(fetch_count), 48'h5);
    halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      redirect_valid = (i % 2) == 0; redirect_target = 16'h1234;
      step();
      check("halt_hold_halted", 48'(halted),    48'h1);
      check("halt_hold_valid",  48'(if_valid),  48'h0);
      check("halt_hold_addr",   48'(imem_addr), 48'h81);
    end
    redirect_valid = 1'b0;

    // Leave HALT via reset, then wrap the PC
    rst = 1'b1;
    step();
    check("halt_rst_halted", 48'(halted), 48'h0);
    rst = 1'b0;
    push(32'hC0DE_FFFF, 16'hFFFF);
    step();
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    step();
    check("wrap_addr",  48'(imem_addr), 48'hFFFF);
    check("wrap_valid", 48'(if_valid),  48'h0);
    redirect_valid = 1'b0;
    step();
    check("wrap_pc_ffff", 48'(if_pc),     48'hFFFF);
    check("wrap_addr0",   48'(imem_addr), 48'h0);
    step();
    id_ready = 1'b0;
    check("wrap_pc_0",   48'(if_pc),       48'h0);
    check("wrap_inst_0", 48'(if_inst),     48'hA);
    check("wrap_count",  48'(fetch_count), 48'h1);
    check("wrap_addr1",  48'(imem_addr),   48'h1);

    // Asynchronous reset mid-stall takes effect without a clock edge
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 48'(if_valid),    48'h0);
    check("arst_pc",    48'(if_pc),       48'h0);
    check("arst_inst",  48'(if_inst),     48'h0);
    check("arst_count", 48'(fetch_count), 48'h0);
    check("arst_addr",  48'(imem_addr),   48'h0);
    push(32'h0000_000A, 16'h0000);
    push(32'h0000_000B, 16'h0001);
    step();
    rst = 1'b0; id_ready = 1'b1;
    step();
    check("arst_bubble", 48'(if_valid), 48'h0);
    step();
    check("arst_f0_pc", 48'(if_pc), 48'h0);
    step();
    check("arst_f1_pc",    48'(if_pc),       48'h1);
    check("arst_f1_count", 48'(fetch_count), 48'h1);
    step();
    id_ready = 1'b0;
    check("arst_f2_count", 48'(fetch_count), 48'h2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("queue_drained", 48'(exp_q.size()), 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
